// File: rtl/dma_pkg.sv
// Shared types for the DMA tile sequencer: transfer type codes, layer types,
// the sequencer state encoding and the issuer phase encoding.
package dma_pkg;

    localparam int INPUT_TYPE_W = 3;

    typedef enum logic [INPUT_TYPE_W-1:0] {
        FILTER = 3'd0,
        IFMAP  = 3'd1,
        BIAS   = 3'd2,
        OPSUM  = 3'd3,
        IPSUM  = 3'd4,
        OFMAP  = 3'd5
    } input_type_e;

    typedef enum logic [1:0] {
        PW  = 2'd0,
        DW  = 2'd1,
        STD = 2'd2,
        LIN = 2'd3
    } layer_type_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FILT      = 4'd1,
        ST_BIAS      = 4'd2,
        ST_IFMAP     = 4'd3,
        ST_IPSUM     = 4'd4,
        ST_COMPUTE   = 4'd5,
        ST_STORE     = 4'd6,
        ST_NEXT_TILE = 4'd7,
        ST_NEXT_PASS = 4'd8,
        ST_DONE      = 4'd9
    } seq_state_e;

    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } xfer_phase_e;

endpackage

// File: rtl/dma_xfer_issuer.sv
// Issues a group of DMA transfers, one per channel, and reports when the
// last one of the group has completed.
//   clk, rst_n      clock, synchronous active-low reset
//   go              parent is in a DMA state; a transfer may be launched
//   group_size      number of transfers in the current group (>= 1)
//   dma_done_i      DMA completion pulse
//   dma_start_o     one-cycle launch pulse
//   last_done       completion of the final transfer of the group
//   ch_cnt          index of the transfer in flight within the group
module dma_xfer_issuer
    import dma_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [IDX_W-1:0] group_size,
    input  logic             dma_done_i,
    output logic             dma_start_o,
    output logic             last_done,
    output logic [IDX_W-1:0] ch_cnt
);

    xfer_phase_e phase;
    logic        accept;

    // The resting phase is ISSUE, so a launch happens on the very first
    // cycle the parent asserts go. A done seen while issuing is dropped.
    assign dma_start_o = go && (phase == PH_ISSUE);
    assign accept      = (phase == PH_WAIT) && dma_done_i;
    assign last_done   = accept && (ch_cnt == group_size - IDX_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= PH_ISSUE;
            ch_cnt <= '0;
        end else if (dma_start_o) begin
            phase <= PH_WAIT;
        end else if (accept) begin
            phase  <= PH_ISSUE;
            ch_cnt <= last_done ? '0 : ch_cnt + IDX_W'(1);
        end
    end

endmodule

// File: rtl/dma_tile_sequencer.sv
// Layer-level DMA sequencer. Walks k (outer) / d (inner) passes, spatial
// tiles and channel groups, launching DMA transfers and PE compute.
//   clk, rst_n                   clock, synchronous active-low reset
//   start_i                      layer start, sampled only in IDLE
//   num_{k,d,n}_tiles_i          loop bounds, latched at start
//   tile_D_i, tile_K_i           channels per ifmap / ofmap tile
//   dma_done_i, compute_done_i   completion pulses
//   dma_start_o, compute_start_o launch pulses
//   input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o  transfer context
//   pass_done_o, layer_done_o    end-of-pass / end-of-layer pulses
//   busy_o                       high outside IDLE
//
// state      | meaning
// IDLE       | waiting for start_i
// FILT       | filter load (one transfer)
// BIAS       | bias load, first d pass only
// IFMAP      | ifmap load, tile_D transfers
// IPSUM      | partial-sum load, tile_K transfers, d > 0 only
// COMPUTE    | PE array running
// STORE      | opsum/ofmap store, tile_K transfers
// NEXT_TILE  | advance spatial tile or end pass
// NEXT_PASS  | advance d, then k, or finish
// DONE       | layer_done pulse
module dma_tile_sequencer
    import dma_pkg::*;
#(
    parameter int IDX_W = 7,
    parameter int NT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [IDX_W-1:0]        num_k_tiles_i,
    input  logic [IDX_W-1:0]        num_d_tiles_i,
    input  logic [NT_W-1:0]         num_n_tiles_i,
    input  logic [IDX_W-1:0]        tile_D_i,
    input  logic [IDX_W-1:0]        tile_K_i,
    input  logic                    dma_done_i,
    input  logic                    compute_done_i,
    output logic                    dma_start_o,
    output logic [INPUT_TYPE_W-1:0] input_type_o,
    output logic [IDX_W-1:0]        k_idx_o,
    output logic [IDX_W-1:0]        d_idx_o,
    output logic [IDX_W-1:0]        ch_cnt_o,
    output logic [NT_W-1:0]         tile_cnt_o,
    output logic                    compute_start_o,
    output logic                    pass_done_o,
    output logic                    layer_done_o,
    output logic                    busy_o
);

    seq_state_e       state, state_nxt;
    logic [IDX_W-1:0] lat_k, lat_d, lat_td, lat_tk;
    logic [NT_W-1:0]  lat_n;
    logic [IDX_W-1:0] k_idx, d_idx;
    logic [NT_W-1:0]  tile_cnt;
    logic             cmp_entry;
    logic             xfer_go, xfer_last;
    logic [IDX_W-1:0] group_size;
    logic             any_zero, d_last, k_last, n_last, d_first;

    assign any_zero = (num_k_tiles_i == '0) || (num_d_tiles_i == '0) ||
                      (num_n_tiles_i == '0) || (tile_D_i == '0) ||
                      (tile_K_i == '0);
    assign d_first  = (d_idx == '0);
    assign d_last   = (d_idx == lat_d - IDX_W'(1));
    assign k_last   = (k_idx == lat_k - IDX_W'(1));
    assign n_last   = (tile_cnt == lat_n - NT_W'(1));

    dma_xfer_issuer #(
        .IDX_W (IDX_W)
    ) u_issuer (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (xfer_go),
        .group_size  (group_size),
        .dma_done_i  (dma_done_i),
        .dma_start_o (dma_start_o),
        .last_done   (xfer_last),
        .ch_cnt      (ch_cnt_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start_i) state_nxt = any_zero ? ST_DONE : ST_FILT;
            ST_FILT:      if (xfer_last) state_nxt = d_first ? ST_BIAS : ST_IFMAP;
            ST_BIAS:      if (xfer_last) state_nxt = ST_IFMAP;
            ST_IFMAP:     if (xfer_last) state_nxt = d_first ? ST_COMPUTE : ST_IPSUM;
            ST_IPSUM:     if (xfer_last) state_nxt = ST_COMPUTE;
            ST_COMPUTE:   if (compute_done_i) state_nxt = ST_STORE;
            ST_STORE:     if (xfer_last) state_nxt = ST_NEXT_TILE;
            ST_NEXT_TILE: state_nxt = n_last ? ST_NEXT_PASS : ST_IFMAP;
            ST_NEXT_PASS: state_nxt = (d_last && k_last) ? ST_DONE : ST_FILT;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Loop counters and latched sizes. Counters are returned to zero on the
    // way into DONE so the done cycle already shows a cleared context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_k     <= '0;
            lat_d     <= '0;
            lat_n     <= '0;
            lat_td    <= '0;
            lat_tk    <= '0;
            k_idx     <= '0;
            d_idx     <= '0;
            tile_cnt  <= '0;
            cmp_entry <= 1'b0;
        end else begin
            cmp_entry <= (state_nxt == ST_COMPUTE) && (state != ST_COMPUTE);
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        lat_k    <= num_k_tiles_i;
                        lat_d    <= num_d_tiles_i;
                        lat_n    <= num_n_tiles_i;
                        lat_td   <= tile_D_i;
                        lat_tk   <= tile_K_i;
                        k_idx    <= '0;
                        d_idx    <= '0;
                        tile_cnt <= '0;
                    end
                end
                ST_NEXT_TILE: tile_cnt <= n_last ? '0 : tile_cnt + NT_W'(1);
                ST_NEXT_PASS: begin
                    if (!d_last) begin
                        d_idx <= d_idx + IDX_W'(1);
                    end else begin
                        d_idx <= '0;
                        k_idx <= k_last ? '0 : k_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        xfer_go         = 1'b0;
        group_size      = '0;
        input_type_o    = FILTER;
        compute_start_o = 1'b0;
        pass_done_o     = 1'b0;
        layer_done_o    = 1'b0;
        busy_o          = (state != ST_IDLE);
        case (state)
            ST_FILT: begin
                xfer_go      = 1'b1;
                group_size   = IDX_W'(1);
                input_type_o = FILTER;
            end
            ST_BIAS: begin
                xfer_go      = 1'b1;
                group_size   = IDX_W'(1);
                input_type_o = BIAS;
            end
            ST_IFMAP: begin
                xfer_go      = 1'b1;
                group_size   = lat_td;
                input_type_o = IFMAP;
            end
            ST_IPSUM: begin
                xfer_go      = 1'b1;
                group_size   = lat_tk;
                input_type_o = IPSUM;
            end
            ST_COMPUTE:   compute_start_o = cmp_entry;
            ST_STORE: begin
                xfer_go      = 1'b1;
                group_size   = lat_tk;
                input_type_o = d_last ? OFMAP : OPSUM;
            end
            ST_NEXT_TILE: pass_done_o = n_last;
            ST_DONE:      layer_done_o = 1'b1;
            default: ;
        endcase
    end

    assign k_idx_o    = k_idx;
    assign d_idx_o    = d_idx;
    assign tile_cnt_o = tile_cnt;

endmodule

// File: tb/tb_dma_tile_sequencer.sv
`timescale 1ns/1ps
module tb_dma_tile_sequencer;
    import dma_pkg::*;

    localparam int IDX_W = 7;
    localparam int NT_W  = 16;

    typedef struct packed {
        logic [2:0]       t;
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] d;
        logic [IDX_W-1:0] ch;
        logic [NT_W-1:0]  n;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [IDX_W-1:0] num_k = '0, num_d = '0, tile_d = '0, tile_k = '0;
    logic [NT_W-1:0]  num_n = '0;
    logic             dma_done_auto = 1'b0, dma_done_man = 1'b0;
    logic             cmp_done_auto = 1'b0, cmp_done_man = 1'b0;
    logic             dma_done_i, compute_done_i;
    logic             dma_start_o, compute_start_o, pass_done_o, layer_done_o, busy_o;
    logic [2:0]       input_type_o;
    logic [IDX_W-1:0] k_idx_o, d_idx_o, ch_cnt_o;
    logic [NT_W-1:0]  tile_cnt_o;

    bit auto_dma = 1'b1, auto_cmp = 1'b1;
    int dma_lat = 0;          // 0 = random 1..4 cycles
    int checks = 0, errors = 0;

    xfer_t            obs_q[$];
    logic [2*IDX_W-1:0] pass_q[$];
    int n_cmp = 0, n_pass = 0, n_layer = 0;

    assign dma_done_i     = dma_done_auto | dma_done_man;
    assign compute_done_i = cmp_done_auto | cmp_done_man;

    always #5 clk = ~clk;

    dma_tile_sequencer #(.IDX_W(IDX_W), .NT_W(NT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .num_k_tiles_i   (num_k),
        .num_d_tiles_i   (num_d),
        .num_n_tiles_i   (num_n),
        .tile_D_i        (tile_d),
        .tile_K_i        (tile_k),
        .dma_done_i      (dma_done_i),
        .compute_done_i  (compute_done_i),
        .dma_start_o     (dma_start_o),
        .input_type_o    (input_type_o),
        .k_idx_o         (k_idx_o),
        .d_idx_o         (d_idx_o),
        .ch_cnt_o        (ch_cnt_o),
        .tile_cnt_o      (tile_cnt_o),
        .compute_start_o (compute_start_o),
        .pass_done_o     (pass_done_o),
        .layer_done_o    (layer_done_o),
        .busy_o          (busy_o)
    );

    always @(negedge clk) begin
        if (dma_start_o) obs_q.push_back({input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o});
        if (pass_done_o) pass_q.push_back({k_idx_o, d_idx_o});
        if (compute_start_o) n_cmp <= n_cmp + 1;
        if (pass_done_o) n_pass <= n_pass + 1;
        if (layer_done_o) n_layer <= n_layer + 1;
    end

    initial begin : dma_responder
        int lat;
        forever begin
            @(negedge clk);
            if (auto_dma && dma_start_o) begin
                lat = (dma_lat > 0) ? dma_lat : int'($urandom_range(1, 4));
                repeat (lat) @(posedge clk);
                #1 dma_done_auto = 1'b1;
                @(posedge clk);
                #1 dma_done_auto = 1'b0;
            end
        end
    end

    initial begin : cmp_responder
        int lat;
        forever begin
            @(negedge clk);
            if (auto_cmp && compute_start_o) begin
                lat = int'($urandom_range(1, 6));
                repeat (lat) @(posedge clk);
                #1 cmp_done_auto = 1'b1;
                @(posedge clk);
                #1 cmp_done_auto = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic xfer_t mk(input logic [2:0] t, input int k, input int d,
                                 input int ch, input int n);
        return {t, IDX_W'(k), IDX_W'(d), IDX_W'(ch), NT_W'(n)};
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Runs a full layer with the automatic responders and compares every
    // transfer, pulse count and pass order against a loop-nest model.
    task automatic run_layer(input string tag, input int K, input int D, input int N,
                             input int TD, input int TK);
        xfer_t              exp_q[$];
        logic [2*IDX_W-1:0] exp_pass[$];
        int base, pbase, c0, p0, l0, got;
        bit done;
        for (int k = 0; k < K; k++) begin
            for (int d = 0; d < D; d++) begin
                exp_q.push_back(mk(FILTER, k, d, 0, 0));
                if (d == 0) exp_q.push_back(mk(BIAS, k, d, 0, 0));
                for (int n = 0; n < N; n++) begin
                    for (int c = 0; c < TD; c++) exp_q.push_back(mk(IFMAP, k, d, c, n));
                    if (d > 0) for (int c = 0; c < TK; c++) exp_q.push_back(mk(IPSUM, k, d, c, n));
                    for (int c = 0; c < TK; c++)
                        exp_q.push_back(mk((d == D - 1) ? OFMAP : OPSUM, k, d, c, n));
                end
                exp_pass.push_back({IDX_W'(k), IDX_W'(d)});
            end
        end
        base = obs_q.size(); pbase = pass_q.size();
        c0 = n_cmp; p0 = n_pass; l0 = n_layer;
        num_k = IDX_W'(K); num_d = IDX_W'(D); num_n = NT_W'(N);
        tile_d = IDX_W'(TD); tile_k = IDX_W'(TK);
        pulse_start();
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (layer_done_o) done = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s layer_done: not seen within cycle budget", tag);
        end
        got = obs_q.size() - base;
        checks++;
        if (got != exp_q.size()) begin
            errors++;
            $display("FAIL %s dma_start count: got %0d expected %0d", tag, got, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            checks++;
            if (obs_q[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s xfer %0d: got t=%0d k=%0d d=%0d ch=%0d n=%0d expected t=%0d k=%0d d=%0d ch=%0d n=%0d",
                         tag, i, obs_q[base+i].t, obs_q[base+i].k, obs_q[base+i].d,
                         obs_q[base+i].ch, obs_q[base+i].n, exp_q[i].t, exp_q[i].k,
                         exp_q[i].d, exp_q[i].ch, exp_q[i].n);
            end
        end
        checks++;
        if (n_cmp - c0 != K * D * N) begin
            errors++;
            $display("FAIL %s compute_start count: got %0d expected %0d", tag, n_cmp - c0, K * D * N);
        end
        checks++;
        if (n_pass - p0 != K * D) begin
            errors++;
            $display("FAIL %s pass_done count: got %0d expected %0d", tag, n_pass - p0, K * D);
        end
        for (int i = 0; i < exp_pass.size() && pbase + i < pass_q.size(); i++) begin
            checks++;
            if (pass_q[pbase+i] !== exp_pass[i]) begin
                errors++;
                $display("FAIL %s pass %0d (k,d): got %h expected %h", tag, i, pass_q[pbase+i], exp_pass[i]);
            end
        end
        checks++;
        if (n_layer - l0 != 1) begin
            errors++;
            $display("FAIL %s layer_done count: got %0d expected 1", tag, n_layer - l0);
        end
        checks++;
        if ({busy_o, k_idx_o, d_idx_o, tile_cnt_o} !== '0) begin
            errors++;
            $display("FAIL %s idle after layer: busy=%0d k=%0d d=%0d tile=%0d expected all 0",
                     tag, busy_o, k_idx_o, d_idx_o, tile_cnt_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o,
             compute_start_o, pass_done_o, layer_done_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got nonzero (busy=%0d type=%0d) expected all 0",
                     busy_o, input_type_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset idle busy: got %0d expected 0", busy_o);
        end
    endtask

    task automatic test_plan_basic();
        dma_lat = 3;
        run_layer("basic_k1d1n2", 1, 1, 2, 2, 3);
        dma_lat = 0;
    endtask

    task automatic test_plan_passes();
        run_layer("passes_k2d2n1", 2, 2, 1, 1, 1);
    endtask

    task automatic test_zero_count();
        int base, c0;
        for (int z = 0; z < 5; z++) begin
            base = obs_q.size(); c0 = n_cmp;
            num_k = (z == 0) ? '0 : IDX_W'(2);
            num_d = (z == 1) ? '0 : IDX_W'(1);
            num_n = (z == 2) ? '0 : NT_W'(2);
            tile_d = (z == 3) ? '0 : IDX_W'(2);
            tile_k = (z == 4) ? '0 : IDX_W'(2);
            pulse_start();
            @(negedge clk);
            checks++;
            if ({layer_done_o, busy_o} !== 2'b11) begin
                errors++;
                $display("FAIL zero%0d done cycle: layer_done=%0d busy=%0d expected 1 1", z, layer_done_o, busy_o);
            end
            @(negedge clk);
            checks++;
            if ({layer_done_o, busy_o} !== 2'b00) begin
                errors++;
                $display("FAIL zero%0d idle cycle: layer_done=%0d busy=%0d expected 0 0", z, layer_done_o, busy_o);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (obs_q.size() != base || n_cmp != c0) begin
                errors++;
                $display("FAIL zero%0d pulses: dma=%0d compute=%0d expected 0 0", z, obs_q.size() - base, n_cmp - c0);
            end
        end
    endtask

    task automatic man_xfer(output bit ok, output logic [9:0] tc);
        ok = 1'b0;
        tc = '0;
        for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
            @(negedge clk);
            if (dma_start_o) begin
                ok = 1'b1;
                tc = {input_type_o, ch_cnt_o};
            end
        end
        @(posedge clk);
        #1 dma_done_man = 1'b1;
        @(posedge clk);
        #1 dma_done_man = 1'b0;
    endtask

    task automatic test_spurious_and_stall();
        bit ok, bad, seen_pass, seen_layer;
        logic [9:0]  tc;
        logic [40:0] snap;
        auto_dma = 1'b0; auto_cmp = 1'b0;
        num_k = 7'd1; num_d = 7'd1; num_n = 16'd1; tile_d = 7'd1; tile_k = 7'd2;
        pulse_start();
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL filt issue: start=%0d type=%0d expected 1 0", dma_start_o, input_type_o);
        end
        dma_done_man = 1'b1;
        @(posedge clk);
        #1 dma_done_man = 1'b0;
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o, ch_cnt_o, busy_o} !== {1'b0, 3'd0, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL done_on_issue: start=%0d type=%0d ch=%0d busy=%0d expected 0 0 0 1",
                     dma_start_o, input_type_o, ch_cnt_o, busy_o);
        end
        dma_done_man = 1'b1;
        @(posedge clk);
        #1 dma_done_man = 1'b0;
        man_xfer(ok, tc);
        checks++;
        if (!ok || tc !== {3'd2, 7'd0}) begin
            errors++;
            $display("FAIL manual bias: ok=%0d type=%0d expected ok=1 type=2", ok, tc[9:7]);
        end
        man_xfer(ok, tc);
        checks++;
        if (!ok || tc !== {3'd1, 7'd0}) begin
            errors++;
            $display("FAIL manual ifmap: ok=%0d type=%0d expected ok=1 type=1", ok, tc[9:7]);
        end
        ok = 1'b0;
        for (int cyc = 0; cyc < 10 && !ok; cyc++) begin
            @(negedge clk);
            if (compute_start_o) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL compute_start: got none expected one pulse");
        end
        snap = {input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o, busy_o};
        @(posedge clk);
        #1 dma_done_man = 1'b1;
        @(posedge clk);
        #1 dma_done_man = 1'b0;
        @(negedge clk);
        checks++;
        if ({input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o, busy_o} !== snap ||
            dma_start_o !== 1'b0 || compute_start_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious dma_done in compute: outputs %h start=%0d expected %h start=0",
                     {input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o, busy_o}, dma_start_o, snap);
        end
        bad = 1'b0;
        repeat (48) begin
            @(negedge clk);
            if (dma_start_o || compute_start_o ||
                {input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o, busy_o} !== snap) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL compute stall: outputs moved or pulse seen, got bad=1 expected 0");
        end
        @(posedge clk);
        #1 cmp_done_man = 1'b1;
        @(posedge clk);
        #1 cmp_done_man = 1'b0;
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o, ch_cnt_o} !== {1'b1, 3'd5, 7'd0}) begin
            errors++;
            $display("FAIL store after compute: start=%0d type=%0d ch=%0d expected 1 5 0",
                     dma_start_o, input_type_o, ch_cnt_o);
        end
        @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o, ch_cnt_o, busy_o, tile_cnt_o} !== {1'b0, 3'd5, 7'd0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL start while busy: start=%0d type=%0d ch=%0d busy=%0d expected 0 5 0 1",
                     dma_start_o, input_type_o, ch_cnt_o, busy_o);
        end
        dma_done_man = 1'b1;
        @(posedge clk);
        #1 dma_done_man = 1'b0;
        man_xfer(ok, tc);
        checks++;
        if (!ok || tc !== {3'd5, 7'd1}) begin
            errors++;
            $display("FAIL second store: ok=%0d type=%0d ch=%0d expected ok=1 5 1", ok, tc[9:7], tc[6:0]);
        end
        seen_pass = 1'b0; seen_layer = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen_layer; cyc++) begin
            @(negedge clk);
            if (pass_done_o) seen_pass = 1'b1;
            if (layer_done_o) seen_layer = 1'b1;
        end
        checks++;
        if (!(seen_pass && seen_layer)) begin
            errors++;
            $display("FAIL manual end: pass_done=%0d layer_done=%0d expected 1 1", seen_pass, seen_layer);
        end
        auto_dma = 1'b1; auto_cmp = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midlayer();
        bit found;
        dma_lat = 3;
        num_k = 7'd1; num_d = 7'd2; num_n = 16'd1; tile_d = 7'd1; tile_k = 7'd2;
        pulse_start();
        found = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            @(negedge clk);
            if (dma_start_o && input_type_o == 3'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset: ipsum issue not seen, got 0 expected 1");
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dma_start_o, input_type_o, k_idx_o, d_idx_o, ch_cnt_o, tile_cnt_o,
             compute_start_o, pass_done_o, layer_done_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL midreset outputs: busy=%0d type=%0d d=%0d ch=%0d expected all 0",
                     busy_o, input_type_o, d_idx_o, ch_cnt_o);
        end
        repeat (8) @(posedge clk);
        #1;
        dma_lat = 0;
        run_layer("after_reset", 1, 2, 1, 1, 2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_layer($sformatf("rand%0d", r), int'($urandom_range(1, 2)), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_plan_basic();
        test_plan_passes();
        test_zero_count();
        test_spurious_and_stall();
        test_reset_midlayer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
